// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer. It feeds a bit-serial
// sequence detector one bit on each enabled cycle, with no gap across word boundaries.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hb_q, hb_d;
  logic             hb_full_q, hb_full_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             word_done_q, word_done_d;
  logic [15:0]      words_sent_q, words_sent_d;

  logic accept;
  logic out_bit;
  logic last_bit;

  // Move the next bit toward the output end and fill the vacated position with zero.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  assign in_ready = ~hb_full_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign out_bit  = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign last_bit = (state_q == StShift) && en && (cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    hb_d         = hb_q;
    hb_full_d    = hb_full_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    words_sent_d = words_sent_q;
    word_done_d  = last_bit;
    x_out        = 1'b0;
    x_valid      = 1'b0;

    // The buffer only accepts a word while it is empty, so accepting a word and
    // draining the buffer into the shift register never happen on the same edge.
    if (accept) begin
      hb_d      = in_data;
      hb_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hb_full_q) begin
          sr_d      = hb_q;
          hb_full_d = 1'b0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        x_out   = out_bit;
        x_valid = en;
        if (en) begin
          if (cnt_q != CntLast) begin
            sr_d  = shift_one(sr_q);
            cnt_d = cnt_q + 1'b1;
          end else begin
            words_sent_d = words_sent_q + 16'd1;
            // Reload on the same edge so the next word's first bit follows with no gap.
            if (hb_full_q) begin
              sr_d      = hb_q;
              hb_full_d = 1'b0;
              cnt_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hb_q         <= '0;
      hb_full_q    <= 1'b0;
      sr_q         <= '0;
      cnt_q        <= '0;
      word_done_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      hb_q         <= hb_d;
      hb_full_q    <= hb_full_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      word_done_q  <= word_done_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign busy       = (state_q == StShift) | hb_full_q;
  assign word_done  = word_done_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share all stimulus.
// Both are checked against a bit-stream model built from the accepted words.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         en;
  logic [W-1:0] in_data;

  logic         in_ready, x_out, x_valid, word_done, busy;
  logic [15:0]  words_sent;
  logic         l_in_ready, l_x_out, l_x_valid, l_word_done, l_busy;
  logic [15:0]  l_words_sent;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .en         (en),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .word_done  (word_done),
    .busy       (busy),
    .words_sent (words_sent)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (l_in_ready),
    .en         (en),
    .x_out      (l_x_out),
    .x_valid    (l_x_valid),
    .word_done  (l_word_done),
    .busy       (l_busy),
    .words_sent (l_words_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each queue holds the bits still owed by that instance, tagged {last_of_word, bit}.
  logic [1:0]  mq[$];
  logic [1:0]  lq[$];
  logic [1:0]  e;
  logic [15:0] m_sent = '0;
  logic [15:0] l_sent = '0;
  bit          m_due  = 1'b0;
  bit          l_due  = 1'b0;
  bit          mon_on = 1'b0;
  int          xv_run = 0;
  int          xv_max = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      check("m_word_done", {31'd0, word_done}, {31'd0, m_due});
      check("l_word_done", {31'd0, l_word_done}, {31'd0, l_due});
      check("m_words_sent", {16'd0, words_sent}, {16'd0, m_sent});
      check("l_words_sent", {16'd0, l_words_sent}, {16'd0, l_sent});
      m_due = 1'b0;
      l_due = 1'b0;
      if (x_valid) begin
        if (mq.size() == 0) check("m_spurious_bit", 32'd1, 32'd0);
        else begin
          e = mq.pop_front();
          check("m_bit", {31'd0, x_out}, {31'd0, e[0]});
          if (e[1]) begin m_due = 1'b1; m_sent = m_sent + 16'd1; end
        end
      end
      if (l_x_valid) begin
        if (lq.size() == 0) check("l_spurious_bit", 32'd1, 32'd0);
        else begin
          e = lq.pop_front();
          check("l_bit", {31'd0, l_x_out}, {31'd0, e[0]});
          if (e[1]) begin l_due = 1'b1; l_sent = l_sent + 16'd1; end
        end
      end
      if (!x_valid && !busy) check("m_idle_out", {31'd0, x_out}, 32'd0);
      if (rst) check("rst_ready", {31'd0, in_ready}, 32'd0);
      else if (!in_ready) check("ready_busy", {31'd0, busy}, 32'd1);
    end
    if (x_valid) begin
      xv_run++;
      if (xv_run > xv_max) xv_max = xv_run;
    end else begin
      xv_run = 0;
    end
    if (rst) begin
      mq.delete();
      lq.delete();
      m_due  = 1'b0;
      l_due  = 1'b0;
      m_sent = '0;
      l_sent = '0;
    end else if (in_valid && in_ready) begin
      for (int i = W - 1; i >= 0; i--) mq.push_back({(i == 0), in_data[i]});
      for (int i = 0; i < W; i++) lq.push_back({(i == W - 1), in_data[i]});
    end
  end

  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !l_busy) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    tick();
  endtask

  logic [W-1:0] w;
  bit           seen;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    en       = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_x_valid", {31'd0, x_valid}, 32'd0);
    check("rst_x_out", {31'd0, x_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_words_sent", {16'd0, words_sent}, 32'd0);
    mon_on = 1'b1;
    tick();

    // Single word A5, MSB first: one idle cycle, eight valid bits, then the done pulse.
    w  = 8'hA5;
    en = 1'b1;
    send(w);
    @(negedge clk);
    check("t1_latency_gap", {31'd0, x_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("t1_valid", {31'd0, x_valid}, 32'd1);
      check("t1_bit", {31'd0, x_out}, {31'd0, w[W-1-i]});
    end
    @(negedge clk);
    check("t1_done", {31'd0, word_done}, 32'd1);
    check("t1_valid_end", {31'd0, x_valid}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t1_done_once", {31'd0, word_done}, 32'd0);
    check("t1_count", {16'd0, words_sent}, 32'd1);
    tick();

    // Back-to-back 05 then 0A: sixteen valid bits with no gap between the words.
    xv_max = 0;
    send(8'h05);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(negedge clk);
    check("t2_ready_low", {31'd0, in_ready}, 32'd0);
    send(8'h0A);
    drain();
    check("t2_run", xv_max, 32'd16);
    check("t2_count", {16'd0, words_sent}, 32'd3);

    // A5 with en low for three cycles while the third bit is on the output.
    send(8'hA5);
    tick();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_valid", {31'd0, x_valid}, 32'd0);
      check("t3_stall_hold", {31'd0, x_out}, 32'd1);
    end
    tick();
    drain();

    // Reset while the fifth bit is out and FF waits in the buffer.
    send(8'hA5);
    send(8'hFF);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_x_valid", {31'd0, x_valid}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_words_sent", {16'd0, words_sent}, 32'd0);
    check("t4_in_ready", {31'd0, in_ready}, 32'd1);
    xv_max = 0;
    repeat (20) @(negedge clk);
    check("t4_no_ff_bits", xv_max, 32'd0);
    tick();

    // LSB-first instance: word 01 leads with a one.
    send(8'h01);
    @(negedge clk);
    @(negedge clk);
    check("t5_l_valid", {31'd0, l_x_valid}, 32'd1);
    check("t5_l_first", {31'd0, l_x_out}, 32'd1);
    check("t5_m_first", {31'd0, x_out}, 32'd0);
    tick();
    drain();

    // Random traffic with random stalls and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();

    // Counter wrap: preset both counters to FFFF, then one more word.
    force u_msb.words_sent_q = 16'hFFFF;
    force u_lsb.words_sent_q = 16'hFFFF;
    m_sent = 16'hFFFF;
    l_sent = 16'hFFFF;
    #1;
    release u_msb.words_sent_q;
    release u_lsb.words_sent_q;
    send(8'h3C);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (word_done) seen = 1'b1;
    end
    check("t6_done_seen", {31'd0, seen}, 32'd1);
    check("t6_wrap", {16'd0, words_sent}, 32'd0);
    check("t6_l_wrap", {16'd0, l_words_sent}, 32'd0);
    drain();

    check("end_m_queue", mq.size(), 32'd0);
    check("end_l_queue", lq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 en  input  1  bit-rate enable; serial stream advances only on cycles with en=1.
REQ-009 x_out  output  1  serial bit to the downstream sequence detector's x input.
REQ-010 x_valid  output  1  x_out is a new, valid bit this cycle.
REQ-011 word_done  output  1  one-cycle pulse, last bit of a word was shifted.
REQ-012 busy  output  1  state is SHIFT or holding buffer is occupied.
REQ-013 words_sent  output  16  count of fully serialized words.

Function
REQ-014 Storage SHALL be one holding buffer HB (WIDTH bits + hb_full flag), shift register SR (WIDTH bits), bit counter cnt (ceil(log2(WIDTH)) bits).
REQ-015 in_ready SHALL equal !hb_full and SHALL be 0 while rst=1.
REQ-016 Handshake: word accepted on an edge where in_valid=1 and in_ready=1; in_data captured into HB, hb_full set.
REQ-017 in_data SHALL be ignored when in_ready=0; no word is dropped or duplicated.
REQ-018 FSM states: IDLE, SHIFT.
REQ-019 IDLE: x_valid=0, x_out=0; if hb_full=1, next edge SHALL load SR<=HB, clear hb_full, cnt<=0, go SHIFT (independent of en).
REQ-020 SHIFT: x_out SHALL be SR[WIDTH-1] when MSB_FIRST=1, else SR[0]; x_valid SHALL equal en.
REQ-021 SHIFT, en=0: SR, cnt, x_out SHALL hold; no bit consumed.
REQ-022 SHIFT, en=1, cnt<WIDTH-1: SR shifts by one toward the output end (zero fill), cnt increments.
REQ-023 SHIFT, en=1, cnt=WIDTH-1: word_done SHALL be high the following cycle; words_sent increments (wraps 16'hFFFF->0).
REQ-024 Same edge as REQ-023: if hb_full=1, SR<=HB, hb_full cleared, cnt<=0, stay SHIFT (no gap bit); else go IDLE.
REQ-025 HB accept and HB->SR transfer cannot coincide (in_ready=0 while hb_full); a word accepted on the transfer edge's following cycle SHALL be held in HB.
REQ-026 Latency: word accepted at edge E -> first bit valid in the cycle after edge E+1 when SR idle.
REQ-027 Throughput: with en=1 constantly and HB refilled in time, one bit per cycle, continuous across word boundaries.
REQ-028 busy SHALL be (state==SHIFT) | hb_full.

Reset
REQ-029 While rst=1 on an edge: state<=IDLE, hb_full<=0, SR<=0, cnt<=0, word_done<=0, words_sent<=0.
REQ-030 After reset: x_out=0, x_valid=0, busy=0, in_ready=1 once rst deasserts; a word in flight or in HB SHALL be discarded.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, en=1, accept 8'hA5 at edge 0 -> x_out 1,0,1,0,0,1,0,1 with x_valid=1 in cycles 2..9; word_done=1 cycle 10 only; words_sent=1; IDLE cycle 10.
REQ-032 Back-to-back 8'h05 then 8'h0A offered continuously -> 16 consecutive x_valid cycles, bits 00000101_00001010, in_ready low whenever HB full, words_sent=2.
REQ-033 8'hA5 with en=0 for 3 cycles after the 3rd bit -> x_valid=0 those cycles, x_out held at 1, remaining bits 0,0,1,0,1 unchanged in order.
REQ-034 rst=1 for one edge while 5th bit is out and HB holds 8'hFF -> next cycle x_valid=0, busy=0, words_sent=0, no 8'hFF bits ever emitted.
REQ-035 MSB_FIRST=0, accept 8'h01 -> first valid bit 1 followed by seven 0s.
REQ-036 Preload words_sent to 16'hFFFF via 65535 words (or force) then one word -> words_sent=16'h0000 with word_done pulse.
